// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter and, later,
// the decode/hazard logic that reasons about the same grant encoding.
package rf_write_arbiter_pkg;

  localparam int RF_ADDR_W = 4;
  localparam int RF_DATA_W = 32;
  localparam int STREAK_W  = 4;

  localparam logic [RF_ADDR_W-1:0] PC_REG_ADDR = 4'hF;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_MEM  = 2'd2
  } gnt_e;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rf_write_arbiter_prio_arb.sv
// Combinational grant picker: MEM wins conflicts until it has won MAX_STREAK
// times in a row against a waiting ALU, then ALU is forced through once.
module rfwa_prio_arb
  import rf_write_arbiter_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic                i_alu_valid,
  input  logic                i_mem_valid,
  input  logic [STREAK_W-1:0] i_streak,
  output gnt_e                o_gnt
);

  localparam logic [STREAK_W-1:0] MaxS = STREAK_W'(MAX_STREAK);

  always_comb begin
    o_gnt = GNT_NONE;
    if (i_alu_valid && i_mem_valid)
      o_gnt = (i_streak >= MaxS) ? GNT_ALU : GNT_MEM;
    else if (i_alu_valid)
      o_gnt = GNT_ALU;
    else if (i_mem_valid)
      o_gnt = GNT_MEM;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single RF write port between ALU and load writeback; r15
// writes become a PC redirect. Optional conflict counter: RFWA_STATS_EN.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int MAX_STREAK = 4,   // legal 1..15
  parameter int CNT_W      = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 stall_i,
  input  logic                 alu_valid_i,
  input  logic [RF_ADDR_W-1:0] alu_addr_i,
  input  logic [RF_DATA_W-1:0] alu_data_i,
  output logic                 alu_ready_o,
  input  logic                 mem_valid_i,
  input  logic [RF_ADDR_W-1:0] mem_addr_i,
  input  logic [RF_DATA_W-1:0] mem_data_i,
  output logic                 mem_ready_o,
  output logic                 wr_en_o,
  output logic [RF_ADDR_W-1:0] wr_addr_o,
  output logic [RF_DATA_W-1:0] wr_data_o,
  output logic                 pc_wr_en_o,
  output logic [RF_DATA_W-1:0] pc_data_o
`ifdef RFWA_STATS_EN
  ,
  output logic [CNT_W-1:0]     conflict_cnt_o
`endif
);

  localparam logic [STREAK_W-1:0] MaxS = STREAK_W'(MAX_STREAK);

  gnt_e                 w_arb_gnt;
  gnt_e                 w_gnt;
  wr_req_t              w_win;
  logic                 w_acc;
  logic                 w_to_pc;
  logic [STREAK_W-1:0]  r_streak;
  logic                 r_wr_en;
  logic [RF_ADDR_W-1:0] r_wr_addr;
  logic [RF_DATA_W-1:0] r_wr_data;
  logic                 r_pc_wr_en;
  logic [RF_DATA_W-1:0] r_pc_data;

  rfwa_prio_arb #(.MAX_STREAK(MAX_STREAK)) u_arb (
    .i_alu_valid (alu_valid_i),
    .i_mem_valid (mem_valid_i),
    .i_streak    (r_streak),
    .o_gnt       (w_arb_gnt)
  );

  always_comb begin
    w_gnt   = (reset_i || stall_i) ? GNT_NONE : w_arb_gnt;
    w_acc   = (w_gnt != GNT_NONE);
    w_win   = (w_gnt == GNT_ALU) ? wr_req_t'{alu_addr_i, alu_data_i}
                                 : wr_req_t'{mem_addr_i, mem_data_i};
    w_to_pc = (w_win.addr == PC_REG_ADDR);
  end

  assign alu_ready_o = (w_gnt == GNT_ALU);
  assign mem_ready_o = (w_gnt == GNT_MEM);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_pc_wr_en <= 1'b0;
      r_pc_data  <= '0;
      r_streak   <= '0;
    end else begin
      r_wr_en    <= w_acc && !w_to_pc;
      r_pc_wr_en <= w_acc && w_to_pc;
      if (w_acc && !w_to_pc) begin
        r_wr_addr <= w_win.addr;
        r_wr_data <= w_win.data;
      end
      if (w_acc && w_to_pc)
        r_pc_data <= w_win.data;
      // Streak only counts MEM wins that actually made the ALU wait.
      if (!stall_i) begin
        if (!alu_valid_i || w_gnt == GNT_ALU)
          r_streak <= '0;
        else if (w_gnt == GNT_MEM && r_streak < MaxS)
          r_streak <= r_streak + 1'b1;
      end
    end
  end

  assign wr_en_o    = r_wr_en;
  assign wr_addr_o  = r_wr_addr;
  assign wr_data_o  = r_wr_data;
  assign pc_wr_en_o = r_pc_wr_en;
  assign pc_data_o  = r_pc_data;

`ifdef RFWA_STATS_EN
  logic [CNT_W-1:0] r_conflict_cnt;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      r_conflict_cnt <= '0;
    else if (!stall_i && alu_valid_i && mem_valid_i && r_conflict_cnt != '1)
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
  end

  assign conflict_cnt_o = r_conflict_cnt;
`endif

  // Upstream must hold a refused request unchanged until it is accepted.
  a_alu_hold: assert property (@(posedge clk_i) disable iff (reset_i)
    (alu_valid_i && !alu_ready_o) |=> (alu_valid_i && $stable(alu_addr_i) && $stable(alu_data_i)));
  a_mem_hold: assert property (@(posedge clk_i) disable iff (reset_i)
    (mem_valid_i && !mem_ready_o) |=> (mem_valid_i && $stable(mem_addr_i) && $stable(mem_data_i)));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a reference model.
module tb_rf_write_arbiter;

  localparam int MAXS   = 4;
  localparam int CNT_W  = 8;
  localparam int N_RAND = 2000;

  logic        clk_i = 1'b0;
  logic        reset_i, stall_i;
  logic        alu_valid_i, mem_valid_i;
  logic [3:0]  alu_addr_i, mem_addr_i;
  logic [31:0] alu_data_i, mem_data_i;
  logic        alu_ready_o, mem_ready_o;
  logic        wr_en_o, pc_wr_en_o;
  logic [3:0]  wr_addr_o;
  logic [31:0] wr_data_o, pc_data_o;
`ifdef RFWA_STATS_EN
  logic [CNT_W-1:0] conflict_cnt_o;
`endif

  int n_checks = 0;
  int n_err    = 0;

  rf_write_arbiter #(.MAX_STREAK(MAXS), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .stall_i     (stall_i),
    .alu_valid_i (alu_valid_i),
    .alu_addr_i  (alu_addr_i),
    .alu_data_i  (alu_data_i),
    .alu_ready_o (alu_ready_o),
    .mem_valid_i (mem_valid_i),
    .mem_addr_i  (mem_addr_i),
    .mem_data_i  (mem_data_i),
    .mem_ready_o (mem_ready_o),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .pc_wr_en_o  (pc_wr_en_o),
    .pc_data_o   (pc_data_o)
`ifdef RFWA_STATS_EN
    ,
    .conflict_cnt_o (conflict_cnt_o)
`endif
  );

  initial forever #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Hold whatever is pending until the DUT has taken it, then go idle.
  task automatic drain();
    logic a, m;
    for (int k = 0; k < 20 && (alu_valid_i || mem_valid_i); k++) begin
      #1;
      a = alu_ready_o;
      m = mem_ready_o;
      step();
      if (a) alu_valid_i = 1'b0;
      if (m) mem_valid_i = 1'b0;
    end
    chk("drain_timeout", {31'd0, alu_valid_i | mem_valid_i}, 32'd0);
  endtask

  // Reference model: state as it must look after the coming clock edge.
  bit          m_init = 1'b0;
  logic        e_wr_en, e_pc_en;
  logic [3:0]  e_wr_addr;
  logic [31:0] e_wr_data, e_pc_data;
  int          mem_wins_alu_waiting;
  int          conflicts;

  initial forever begin
    bit e_alu_rdy, e_mem_rdy;
    @(negedge clk_i);
    e_alu_rdy = 0;
    e_mem_rdy = 0;
    if (!reset_i && !stall_i) begin
      if (alu_valid_i && mem_valid_i) begin
        if (mem_wins_alu_waiting == MAXS) e_alu_rdy = 1;
        else                              e_mem_rdy = 1;
      end else begin
        e_alu_rdy = alu_valid_i;
        e_mem_rdy = mem_valid_i;
      end
    end
    if (m_init) begin
      chk("m_alu_ready", {31'd0, alu_ready_o}, {31'd0, e_alu_rdy});
      chk("m_mem_ready", {31'd0, mem_ready_o}, {31'd0, e_mem_rdy});
      chk("m_wr_en",     {31'd0, wr_en_o},     {31'd0, e_wr_en});
      chk("m_wr_addr",   {28'd0, wr_addr_o},   {28'd0, e_wr_addr});
      chk("m_wr_data",   wr_data_o,            e_wr_data);
      chk("m_pc_wr_en",  {31'd0, pc_wr_en_o},  {31'd0, e_pc_en});
      chk("m_pc_data",   pc_data_o,            e_pc_data);
`ifdef RFWA_STATS_EN
      chk("m_conflict",  32'(conflict_cnt_o),  32'(conflicts));
`endif
    end
    if (reset_i) begin
      m_init = 1;
      e_wr_en = 0; e_pc_en = 0; e_wr_addr = 0; e_wr_data = 0; e_pc_data = 0;
      mem_wins_alu_waiting = 0;
      conflicts = 0;
    end else if (m_init) begin
      logic [3:0]  a;
      logic [31:0] d;
      a = e_alu_rdy ? alu_addr_i : mem_addr_i;
      d = e_alu_rdy ? alu_data_i : mem_data_i;
      e_wr_en = 0;
      e_pc_en = 0;
      if (e_alu_rdy || e_mem_rdy) begin
        if (a == 4'd15) begin
          e_pc_en = 1; e_pc_data = d;
        end else begin
          e_wr_en = 1; e_wr_addr = a; e_wr_data = d;
        end
      end
      if (!stall_i) begin
        if (!alu_valid_i || e_alu_rdy) mem_wins_alu_waiting = 0;
        else if (e_mem_rdy && mem_wins_alu_waiting < MAXS) mem_wins_alu_waiting++;
        if (alu_valid_i && mem_valid_i && conflicts < (1 << CNT_W) - 1) conflicts++;
      end
    end
  end

  initial begin
    logic a_rdy, m_rdy;
    reset_i = 1; stall_i = 0;
    alu_valid_i = 0; alu_addr_i = 0; alu_data_i = 0;
    mem_valid_i = 0; mem_addr_i = 0; mem_data_i = 0;
    step(); step();
    chk("rst_wr_en",   {31'd0, wr_en_o},    32'd0);
    chk("rst_wr_addr", {28'd0, wr_addr_o},  32'd0);
    chk("rst_wr_data", wr_data_o,           32'd0);
    chk("rst_pc_en",   {31'd0, pc_wr_en_o}, 32'd0);
    chk("rst_pc_data", pc_data_o,           32'd0);
    reset_i = 0;

    // ALU alone
    alu_valid_i = 1; alu_addr_i = 3; alu_data_i = 32'hDEAD_BEEF;
    #1 chk("alu_only_rdy", {31'd0, alu_ready_o}, 32'd1);
    step();
    alu_valid_i = 0;
    chk("alu_only_en",   {31'd0, wr_en_o},   32'd1);
    chk("alu_only_addr", {28'd0, wr_addr_o}, 32'd3);
    chk("alu_only_data", wr_data_o,          32'hDEAD_BEEF);
    step(); step();

    // Continuous conflict: MEM x4, ALU, MEM
    alu_valid_i = 1; alu_addr_i = 2; alu_data_i = 32'h0000_00AA;
    mem_valid_i = 1; mem_addr_i = 5; mem_data_i = 32'h0000_00BB;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("starve_alu_rdy", {31'd0, alu_ready_o}, (c == 4) ? 32'd1 : 32'd0);
      chk("starve_mem_rdy", {31'd0, mem_ready_o}, (c == 4) ? 32'd0 : 32'd1);
      step();
      chk("starve_wr_addr", {28'd0, wr_addr_o}, (c == 4) ? 32'd2 : 32'd5);
    end
    drain();
    step(); step();

    // PC redirect
    mem_valid_i = 1; mem_addr_i = 15; mem_data_i = 32'h100;
    #1 chk("pc_rdy", {31'd0, mem_ready_o}, 32'd1);
    step();
    mem_valid_i = 0;
    chk("pc_en",      {31'd0, pc_wr_en_o}, 32'd1);
    chk("pc_data",    pc_data_o,           32'h100);
    chk("pc_no_wr",   {31'd0, wr_en_o},    32'd0);
    step();
    chk("pc_en_off",  {31'd0, pc_wr_en_o}, 32'd0);
    chk("pc_hold",    pc_data_o,           32'h100);

    // Stall freezes a streak of 2; afterwards two more MEM wins then ALU
    alu_valid_i = 1; alu_addr_i = 1; alu_data_i = 32'h11;
    mem_valid_i = 1; mem_addr_i = 4; mem_data_i = 32'h44;
    step(); step();
    stall_i = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_alu_rdy", {31'd0, alu_ready_o}, 32'd0);
      chk("stall_mem_rdy", {31'd0, mem_ready_o}, 32'd0);
      step();
      chk("stall_wr_en", {31'd0, wr_en_o}, 32'd0);
    end
    stall_i = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("unstall_mem_rdy", {31'd0, mem_ready_o}, (c < 2) ? 32'd1 : 32'd0);
      chk("unstall_alu_rdy", {31'd0, alu_ready_o}, (c == 2) ? 32'd1 : 32'd0);
      step();
    end
    drain();
    step(); step();

    // Reset while a request is pending: it is dropped, then accepted later
    alu_valid_i = 1; alu_addr_i = 7; alu_data_i = 32'h77;
    reset_i = 1;
    #1 chk("rstmid_rdy", {31'd0, alu_ready_o}, 32'd0);
    step();
    reset_i = 0;
    chk("rstmid_wr_en",   {31'd0, wr_en_o},   32'd0);
    chk("rstmid_wr_addr", {28'd0, wr_addr_o}, 32'd0);
    chk("rstmid_wr_data", wr_data_o,          32'd0);
    chk("rstmid_pc_data", pc_data_o,          32'd0);
    #1 chk("rstmid_after_rdy", {31'd0, alu_ready_o}, 32'd1);
    step();
    alu_valid_i = 0;
    chk("rstmid_after_addr", {28'd0, wr_addr_o}, 32'd7);
    chk("rstmid_after_data", wr_data_o,          32'h77);
    step();

`ifdef RFWA_STATS_EN
    reset_i = 1; step(); reset_i = 0;
    chk("stats_rst", 32'(conflict_cnt_o), 32'd0);
    alu_valid_i = 1; alu_addr_i = 6; alu_data_i = 32'h66;
    mem_valid_i = 1; mem_addr_i = 8; mem_data_i = 32'h88;
    for (int c = 0; c < 5; c++) begin
      stall_i = (c == 2);
      step();
    end
    stall_i = 0;
    chk("stats_four", 32'(conflict_cnt_o), 32'd4);
    for (int c = 0; c < (1 << CNT_W) + 3; c++) step();
    chk("stats_sat", 32'(conflict_cnt_o), 32'((1 << CNT_W) - 1));
    drain();
    step();
`endif

    // Randomized traffic, honouring hold-until-accepted
    a_rdy = 0; m_rdy = 0;
    for (int i = 0; i < N_RAND; i++) begin
      if (!alu_valid_i || a_rdy) begin
        alu_valid_i = ($urandom_range(0, 99) < 60);
        alu_addr_i  = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
        alu_data_i  = $urandom;
      end
      if (!mem_valid_i || m_rdy) begin
        mem_valid_i = ($urandom_range(0, 99) < 60);
        mem_addr_i  = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
        mem_data_i  = $urandom;
      end
      stall_i = ($urandom_range(0, 99) < 10);
      reset_i = ($urandom_range(0, 99) < 2);
      #1;
      a_rdy = alu_ready_o;
      m_rdy = mem_ready_o;
      step();
    end
    reset_i = 0; stall_i = 0;
    drain();
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: ALU result (alu_*) and memory load (mem_*).
- Each source uses a valid/ready handshake. A fixed priority applies, with an anti-starvation override.
- The winner's write is registered and driven to the register file's wr_en_i/wr_addr_i/data_i one cycle after acceptance.
- Writes to r15 (PC) do not go to the register file; they go to a separate PC-redirect output.

Parameters:
- MAX_STREAK, 4: max consecutive MEM grants while ALU is waiting; the next grant is then forced to ALU. Legal range 1..15.
- CNT_W, 16: width of the optional conflict counter.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- stall_i  in  1  freeze: no acceptance this cycle
- alu_valid_i  in  1  ALU write request
- alu_addr_i  in  4  ALU destination register
- alu_data_i  in  32  ALU write data
- alu_ready_o  out  1  ALU request accepted this cycle
- mem_valid_i  in  1  load write request
- mem_addr_i  in  4  load destination register
- mem_data_i  in  32  load write data
- mem_ready_o  out  1  load request accepted this cycle
- wr_en_o  out  1  to register file wr_en_i
- wr_addr_o  out  4  to register file wr_addr_i
- wr_data_o  out  32  to register file data_i
- pc_wr_en_o  out  1  PC redirect strobe (write to r15)
- pc_data_o  out  32  PC redirect value
- conflict_cnt_o  out  CNT_W  saturating count of cycles with both sources valid (only with RFWA_STATS_EN)

Behaviour:
- Grant logic (combinational from inputs and streak state):
  - stall_i=1 or reset_i=1: both ready = 0.
  - Only one source valid: that source is granted.
  - Both valid: MEM is granted unless streak == MAX_STREAK, in which case ALU is granted.
  - ready_o = granted. Acceptance = valid & ready.
- Streak counter (4-bit):
  - Increments on a MEM grant while alu_valid_i=1.
  - Clears on any ALU grant, and on any cycle where alu_valid_i=0.
  - Holds during stall_i.
  - Never exceeds MAX_STREAK.
- Output register, latency 1: on acceptance of addr A, data D:
  - A != 15: next cycle wr_en_o=1, wr_addr_o=A, wr_data_o=D, pc_wr_en_o=0.
  - A == 15: next cycle pc_wr_en_o=1, pc_data_o=D, wr_en_o=0.
  - No acceptance: next cycle wr_en_o=0 and pc_wr_en_o=0. wr_addr_o, wr_data_o and pc_data_o hold their last values.
- Ordering: when both are valid and target the same register, the granted write lands first. The loser lands in a later cycle, and its value is final. Upstream relies on this ordering.
- Throughput: at most one accepted write per cycle. Back-to-back acceptances give back-to-back wr_en_o pulses.
- Request stability: a source must hold valid/addr/data stable until accepted. This is checked by assertion, not enforced in RTL.
- Reset, including mid-operation:
  - Next cycle: wr_en_o=0, wr_addr_o=0, wr_data_o=0, pc_wr_en_o=0, pc_data_o=0, streak=0, conflict_cnt_o=0.
  - Any write accepted in the reset cycle is dropped.

Optional Feature:
- RFWA_STATS_EN defined: conflict_cnt_o exists. It increments on every non-stalled, non-reset cycle with alu_valid_i & mem_valid_i, and saturates at all-ones.
- RFWA_STATS_EN undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package:
  - RF_ADDR_W=4, RF_DATA_W=32.
  - PC_REG_ADDR=4'hF.
  - A grant encoding type {GNT_NONE, GNT_ALU, GNT_MEM}, also used by future decode/hazard logic.
- Sub-module rfwa_prio_arb: a pure combinational grant picker (valids, streak, MAX_STREAK -> grant). It is split out so it can be verified exhaustively.
- Streak counter, output register and stats counter live in the top module.

Test Plan:
- Only ALU: alu_valid=1, addr=3, data=32'hDEAD_BEEF for 1 cycle -> alu_ready=1. Next cycle wr_en_o=1, wr_addr_o=3, wr_data_o=DEADBEEF.
- Conflict with starvation, MAX_STREAK=4: both valid continuously (ALU addr 2, MEM addr 5) -> MEM granted cycles 0-3, ALU granted cycle 4, MEM again cycle 5.
- PC write: mem_valid=1, addr=15, data=32'h100 -> next cycle pc_wr_en_o=1, pc_data_o=32'h100, wr_en_o=0.
- Stall: both valid with stall_i=1 for 3 cycles -> both ready=0, wr_en_o=0, streak unchanged. Release -> MEM granted.
- Reset mid-operation: acceptance and reset_i=1 in the same cycle -> next cycle all outputs 0, no write issued, streak=0.
- RFWA_STATS_EN: 5 conflict cycles, 1 of them stalled -> conflict_cnt_o=4. Force 2^CNT_W+3 conflicts -> counter holds at all-ones.
